// File: rtl/nabp_filtered_ram_swap_control.sv
// Ping-pong projection-line store: one bank fills from the host filter stream while the other serves reads.
// Optional second read port is enabled by defining NABP_FILTERED_RAM_PR1_EN.
module nabp_filtered_ram_swap_control #(
    parameter int kAngleLength        = 9,
    parameter int kSLength            = 9,
    parameter int kFilteredDataLength = 12,
    parameter int kLineSize           = 256,
    parameter int kFillLatency        = 5
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [kAngleLength-1:0]        hs_angle,
    input  logic                           hs_has_next_angle,
    input  logic                           hs_next_angle_ack,
    input  logic [kFilteredDataLength-1:0] hs_val,
    input  logic [kSLength-1:0]            pr0_s_val,
    input  logic [kSLength-1:0]            pr1_s_val,
    input  logic                           pr_next_angle,
    output logic [kSLength-1:0]            hs_s_val,
    output logic                           hs_next_angle,
    output logic [kAngleLength-1:0]        pr_angle,
    output logic                           pr_next_angle_ack,
    output logic [kFilteredDataLength-1:0] pr0_val,
    output logic [kFilteredDataLength-1:0] pr1_val
);

    localparam int AW = $clog2(kLineSize);
    localparam int DW = $clog2(kFillLatency + 1);
    localparam logic [kSLength-1:0] LAST_S     = kSLength'(kLineSize - 1);
    localparam logic [DW-1:0]       DRAIN_LAST = DW'(kFillLatency - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FULL  = 3'd3,
        ST_REQ   = 3'd4
    } state_t;

    state_t                         state_q;
    logic [kSLength-1:0]            hs_s_val_q;
    logic                           hs_next_angle_q;
    logic [kAngleLength-1:0]        fill_angle_q;
    logic [kAngleLength-1:0]        pr_angle_q;
    logic                           ack_q;
    logic                           fill_sel_q;
    logic [DW-1:0]                  drain_cnt_q;

    logic [AW-1:0]                  sr_addr_q [kFillLatency];
    logic                           sr_vld_q  [kFillLatency];

    logic [kFilteredDataLength-1:0] bank0_q [kLineSize];
    logic [kFilteredDataLength-1:0] bank1_q [kLineSize];

    logic [kFilteredDataLength-1:0] pr0_val_d;
    logic [kFilteredDataLength-1:0] pr1_val_d;
    logic [kFilteredDataLength-1:0] pr0_val_q;
    logic [kFilteredDataLength-1:0] pr1_val_q;

    // Fill/swap controller with registered handshake outputs.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q         <= ST_IDLE;
            hs_s_val_q      <= '0;
            hs_next_angle_q <= 1'b0;
            fill_angle_q    <= '0;
            pr_angle_q      <= '0;
            ack_q           <= 1'b0;
            fill_sel_q      <= 1'b0;
            drain_cnt_q     <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    hs_s_val_q      <= '0;
                    hs_next_angle_q <= 1'b0;
                    if (hs_has_next_angle) begin
                        fill_angle_q <= hs_angle;
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (hs_s_val_q == LAST_S) begin
                        hs_s_val_q  <= '0;
                        drain_cnt_q <= '0;
                        state_q     <= ST_DRAIN;
                    end else begin
                        hs_s_val_q <= hs_s_val_q + kSLength'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= ST_FULL;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DW'(1);
                    end
                end
                ST_FULL: begin
                    if (pr_next_angle) begin
                        fill_sel_q <= ~fill_sel_q;
                        pr_angle_q <= fill_angle_q;
                        ack_q      <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The request rises one cycle after the swap pulse; an ack only counts once it is up.
                    if (!hs_has_next_angle) begin
                        hs_next_angle_q <= 1'b0;
                        state_q         <= ST_IDLE;
                    end else if (hs_next_angle_q && hs_next_angle_ack) begin
                        hs_next_angle_q <= 1'b0;
                        fill_angle_q    <= hs_angle;
                        hs_s_val_q      <= '0;
                        state_q         <= ST_FILL;
                    end else begin
                        hs_next_angle_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Address/valid delay line matching the host RAM plus filter latency.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < kFillLatency; i++) begin
                sr_addr_q[i] <= '0;
                sr_vld_q[i]  <= 1'b0;
            end
        end else begin
            sr_addr_q[0] <= hs_s_val_q[AW-1:0];
            sr_vld_q[0]  <= (state_q == ST_FILL);
            for (int i = 1; i < kFillLatency; i++) begin
                sr_addr_q[i] <= sr_addr_q[i-1];
                sr_vld_q[i]  <= sr_vld_q[i-1];
            end
        end
    end

    // Fill-bank write of the delayed sample.
    always_ff @(posedge clk) begin
        if (sr_vld_q[kFillLatency-1]) begin
            if (fill_sel_q) begin
                bank1_q[sr_addr_q[kFillLatency-1]] <= hs_val;
            end else begin
                bank0_q[sr_addr_q[kFillLatency-1]] <= hs_val;
            end
        end
    end

    // Port 0 read from the processing bank; out-of-line addresses read as zero.
    always_comb begin
        pr0_val_d = '0;
        if (int'(pr0_s_val) < kLineSize) begin
            if (fill_sel_q) begin
                pr0_val_d = bank0_q[pr0_s_val[AW-1:0]];
            end else begin
                pr0_val_d = bank1_q[pr0_s_val[AW-1:0]];
            end
        end else begin
            pr0_val_d = '0;
        end
    end

`ifdef NABP_FILTERED_RAM_PR1_EN
    // Port 1 read, identical to port 0.
    always_comb begin
        pr1_val_d = '0;
        if (int'(pr1_s_val) < kLineSize) begin
            if (fill_sel_q) begin
                pr1_val_d = bank0_q[pr1_s_val[AW-1:0]];
            end else begin
                pr1_val_d = bank1_q[pr1_s_val[AW-1:0]];
            end
        end else begin
            pr1_val_d = '0;
        end
    end
`else
    logic pr1_unused;
    assign pr1_unused = ^pr1_s_val;
    assign pr1_val_d  = '0;
`endif

    // Registered read data.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            pr0_val_q <= '0;
            pr1_val_q <= '0;
        end else begin
            pr0_val_q <= pr0_val_d;
            pr1_val_q <= pr1_val_d;
        end
    end

    assign hs_s_val          = hs_s_val_q;
    assign hs_next_angle     = hs_next_angle_q;
    assign pr_angle          = pr_angle_q;
    assign pr_next_angle_ack = ack_q;
    assign pr0_val           = pr0_val_q;
    assign pr1_val           = pr1_val_q;

endmodule

// File: tb/tb_nabp_filtered_ram_swap_control.sv
// Bench for nabp_filtered_ram_swap_control: host model with a 5-cycle sample delay plus a read scoreboard.
module tb_nabp_filtered_ram_swap_control;

    localparam int LINE = 256;

    logic        clk;
    logic        reset_n;
    logic [8:0]  hs_angle;
    logic        hs_has_next_angle;
    logic        hs_next_angle_ack;
    logic [11:0] hs_val;
    logic [8:0]  pr0_s_val;
    logic [8:0]  pr1_s_val;
    logic        pr_next_angle;
    logic [8:0]  hs_s_val;
    logic        hs_next_angle;
    logic [8:0]  pr_angle;
    logic        pr_next_angle_ack;
    logic [11:0] pr0_val;
    logic [11:0] pr1_val;

    nabp_filtered_ram_swap_control dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .hs_angle          (hs_angle),
        .hs_has_next_angle (hs_has_next_angle),
        .hs_next_angle_ack (hs_next_angle_ack),
        .hs_val            (hs_val),
        .pr0_s_val         (pr0_s_val),
        .pr1_s_val         (pr1_s_val),
        .pr_next_angle     (pr_next_angle),
        .hs_s_val          (hs_s_val),
        .hs_next_angle     (hs_next_angle),
        .pr_angle          (pr_angle),
        .pr_next_angle_ack (pr_next_angle_ack),
        .pr0_val           (pr0_val),
        .pr1_val           (pr1_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          exp_ang = 0;
    int          host_next_ang = 0;
    bit          host_auto = 1'b0;
    int          hist_s [6];
    int          hist_a [6];
    logic [11:0] exp0_q [$];
    logic [11:0] exp1_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] line_val(input int ang, input int s);
        logic [31:0] v;
        if (s >= LINE) return 12'd0;
        v = s * ang + 87;
        return v[11:0];
    endfunction

    // One clock: host sample stream (5-cycle delay) and optional automatic angle ack.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 5; i > 0; i--) begin
            hist_s[i] = hist_s[i-1];
            hist_a[i] = hist_a[i-1];
        end
        hist_s[0] = int'(hs_s_val);
        hist_a[0] = int'(hs_angle);
        hs_val = line_val(hist_a[5], hist_s[5]);
        if (host_auto && hs_next_angle === 1'b1 && hs_next_angle_ack == 1'b0) begin
            hs_angle = host_next_ang[8:0];
            host_next_ang += 20;
            hs_next_angle_ack = 1'b1;
        end else begin
            hs_next_angle_ack = 1'b0;
        end
    endtask

    task automatic rd(input int a0, input int a1);
        pr0_s_val = a0[8:0];
        pr1_s_val = a1[8:0];
        exp0_q.push_back(line_val(exp_ang, a0));
`ifdef NABP_FILTERED_RAM_PR1_EN
        exp1_q.push_back(line_val(exp_ang, a1));
`else
        exp1_q.push_back(12'd0);
`endif
        tick();
        check_val($sformatf("pr0[%0d]", a0), 32'(pr0_val), 32'(exp0_q.pop_front()));
        check_val($sformatf("pr1[%0d]", a1), 32'(pr1_val), 32'(exp1_q.pop_front()));
    endtask

    task automatic wait_ack(input string tag, input int budget, output int at);
        bit got;
        got = 1'b0;
        at  = -1;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (pr_next_angle_ack === 1'b1) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        check_val({tag, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            tick();
            check_val({tag, "_width"}, 32'(pr_next_angle_ack), 32'd0);
            check_val({tag, "_hsreq"}, 32'(hs_next_angle), 32'd1);
        end
    endtask

    initial begin
        int at, c0, prev, n_ack, n_req;
        bit got;
        for (int i = 0; i < 6; i++) begin
            hist_s[i] = 0;
            hist_a[i] = 0;
        end
        reset_n           = 1'b0;
        hs_angle          = 9'd0;
        hs_has_next_angle = 1'b1;
        hs_next_angle_ack = 1'b0;
        hs_val            = 12'd0;
        pr0_s_val         = 9'd0;
        pr1_s_val         = 9'd0;
        pr_next_angle     = 1'b0;
        #1 reset_n = 1'b1;
        repeat (3) tick();
        check_val("rst_hs_s_val", 32'(hs_s_val), 32'd0);
        check_val("rst_hs_next", 32'(hs_next_angle), 32'd0);
        check_val("rst_pr_angle", 32'(pr_angle), 32'd0);
        check_val("rst_ack", 32'(pr_next_angle_ack), 32'd0);
        check_val("rst_pr0", 32'(pr0_val), 32'd0);
        check_val("rst_pr1", 32'(pr1_val), 32'd0);

        // First line at angle 0, processing side already asking for an angle.
        reset_n       = 1'b0;
        c0            = cyc;
        pr_next_angle = 1'b1;
        wait_ack("swap0", 400, at);
        check_val("fill_lat0", 32'(at - c0), 32'd263);
        check_val("pr_angle0", 32'(pr_angle), 32'd0);
        exp_ang       = 0;
        pr_next_angle = 1'b0;
        host_next_ang = 20;
        host_auto     = 1'b1;
        for (int s = 0; s < 260; s++) rd(s, 259 - s);
        repeat (20) tick();

        // Swap from FULL is one cycle after the request.
        pr_next_angle = 1'b1;
        c0            = cyc;
        wait_ack("swap20", 4, at);
        check_val("swap_lat20", 32'(at - c0), 32'd1);
        check_val("pr_angle20", 32'(pr_angle), 32'd20);
        exp_ang = 20;
        rd(10, 10);
        check_val("s10_a20", 32'(pr0_val), 32'd287);
        prev = at;

        // Request held through the fill: back-to-back swaps at the minimum period.
        for (int a = 40; a <= 160; a += 20) begin
            for (int k = 0; k < 8; k++) rd(int'($urandom_range(0, 300)), int'($urandom_range(0, 511)));
            wait_ack($sformatf("swap%0d", a), 300, at);
            check_val($sformatf("period%0d", a), 32'(at - prev), 32'd264);
            check_val($sformatf("pr_angle%0d", a), 32'(pr_angle), 32'(a));
            exp_ang = a;
            prev    = at;
        end
        pr_next_angle = 1'b0;

        // FULL with no request: nothing moves.
        repeat (300) tick();
        n_ack = 0;
        n_req = 0;
        repeat (1000) begin
            tick();
            if (pr_next_angle_ack === 1'b1) n_ack++;
            if (hs_next_angle === 1'b1) n_req++;
        end
        check_val("hold_acks", 32'(n_ack), 32'd0);
        check_val("hold_reqs", 32'(n_req), 32'd0);
        check_val("hold_pr_angle", 32'(pr_angle), 32'd160);

        // Host runs dry while a request is pending.
        host_auto     = 1'b0;
        pr_next_angle = 1'b1;
        c0            = cyc;
        wait_ack("swap180", 4, at);
        check_val("swap_lat180", 32'(at - c0), 32'd1);
        check_val("pr_angle180", 32'(pr_angle), 32'd180);
        exp_ang = 180;
        tick();
        check_val("req_hold", 32'(hs_next_angle), 32'd1);
        hs_has_next_angle = 1'b0;
        tick();
        check_val("req_drop", 32'(hs_next_angle), 32'd0);
        n_ack = 0;
        repeat (300) begin
            tick();
            if (pr_next_angle_ack === 1'b1) n_ack++;
        end
        check_val("idle_acks", 32'(n_ack), 32'd0);
        check_val("idle_s", 32'(hs_s_val), 32'd0);
        check_val("idle_pr_angle", 32'(pr_angle), 32'd180);
        rd(0, 1);
        rd(255, 254);
        rd(300, 400);

        // Reset in the middle of a fill, then a clean refill.
        hs_angle          = 9'd200;
        hs_has_next_angle = 1'b1;
        got               = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (hs_s_val === 9'd100) got = 1'b1;
        end
        check_val("reach_s100", 32'(got), 32'd1);
        #2 reset_n = 1'b1;
        #1;
        check_val("mrst_hs_s_val", 32'(hs_s_val), 32'd0);
        check_val("mrst_hs_next", 32'(hs_next_angle), 32'd0);
        check_val("mrst_pr_angle", 32'(pr_angle), 32'd0);
        check_val("mrst_ack", 32'(pr_next_angle_ack), 32'd0);
        check_val("mrst_pr0", 32'(pr0_val), 32'd0);
        check_val("mrst_pr1", 32'(pr1_val), 32'd0);
        tick();
        reset_n = 1'b0;
        c0      = cyc;
        tick();
        check_val("refill_s0", 32'(hs_s_val), 32'd0);
        tick();
        check_val("refill_s1", 32'(hs_s_val), 32'd1);
        wait_ack("swap200", 400, at);
        check_val("fill_lat200", 32'(at - c0), 32'd263);
        check_val("pr_angle200", 32'(pr_angle), 32'd200);
        exp_ang = 200;
        rd(0, 0);
        rd(1, 99);
        rd(100, 101);
        rd(255, 256);
        rd(256, 511);
        for (int k = 0; k < 8; k++) rd(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nabp_filtered_ram_swap_control.md
# nabp_filtered_ram_swap_control

Double-buffered (ping-pong) projection-line store between the host-side filter pipeline and the back-projection processing units. While one bank is filled with the filtered samples of the next angle, the other bank serves random-access reads from the processing side. Banks swap on a handshake once the fill is complete and processing requests a new angle.

## Interface
- kAngleLength, 9, angle width
- kSLength, 9, sample-index width
- kFilteredDataLength, 12, filtered sample width
- kLineSize, 256, samples per projection line (indices 0..kLineSize-1)
- kFillLatency, 5, cycles from `hs_s_val` issue to the matching `hs_val` (1 host RAM read plus filter order/2 = 4)
- clk  in  1  clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-high reset (asserted = 1; the name is the codebase's)
- hs_angle  in  kAngleLength  angle of the line currently presented by the host
- hs_has_next_angle  in  1  host has an angle to deliver
- hs_next_angle_ack  in  1  host has updated `hs_angle` after a request
- hs_val  in  kFilteredDataLength  filtered sample stream
- pr0_s_val, pr1_s_val  in  kSLength  read addresses, ports 0/1
- pr_next_angle  in  1  processing requests a new angle
- hs_s_val  out  kSLength  host RAM read address
- hs_next_angle  out  1  request next angle from host (also clears the filter)
- pr_angle  out  kAngleLength  angle held in the processing bank
- pr_next_angle_ack  out  1  swap-done pulse
- pr0_val, pr1_val  out  kFilteredDataLength  read data, ports 0/1

## Operation
- Two banks, kLineSize x kFilteredDataLength each; `fill_sel` names the fill bank, the other bank is the processing bank.
- Fill FSM:
  - IDLE: if `hs_has_next_angle`=1, latch `hs_angle` into `fill_angle`, go FILL; else stay.
  - FILL: `hs_s_val` counts 0..kLineSize-1, one per cycle; go DRAIN after kLineSize-1.
  - DRAIN: kFillLatency cycles until the last write lands; go FULL.
  - FULL: wait for a swap; then go REQ.
  - REQ: hold `hs_next_angle`=1 until `hs_next_angle_ack`=1 is sampled. On that edge, deassert, latch `hs_angle`, go FILL. If `hs_has_next_angle`=0 while in REQ, go IDLE with `hs_next_angle`=0.
- Write path: `hs_s_val` and a valid flag pass through a kFillLatency-deep shift register. When the delayed valid is set, write `hs_val` to the fill bank at the delayed address. The first kFillLatency samples after a request are written at correct addresses (filter-cleared zeros upstream are never written).
- Swap: in FULL with `pr_next_angle`=1, toggle `fill_sel`, set `pr_angle` <= `fill_angle`, and pulse `pr_next_angle_ack` for exactly 1 cycle.
- If `pr_next_angle` rises during FILL/DRAIN, it waits; the swap occurs on the first FULL cycle.
- Reads: `prN_val` <= processing_bank[`prN_s_val`], registered. Addresses >= kLineSize return 0.
- Reset: `fill_sel`=0, FSM=IDLE, `hs_s_val`=0, `hs_next_angle`=0, `pr_angle`=0, `pr_next_angle_ack`=0, `pr0_val`/`pr1_val`=0, shift register valid bits cleared. Bank contents are undefined. Reset mid-fill abandons the fill; no stale write follows.

## Timing
- Read latency 1 cycle: address at edge n gives data valid after edge n+1.
- Fill of one line: kLineSize + kFillLatency cycles from entering FILL to FULL.
- `pr_next_angle_ack` rises the cycle after FULL and `pr_next_angle` are both 1. `hs_next_angle` rises the following cycle.
- Minimum angle period = kLineSize + kFillLatency + 3 cycles plus host ack delay.
- Reads of the processing bank are unaffected by fill writes, including writes in the swap cycle.

## Configuration
- `NABP_FILTERED_RAM_PR1_EN` defined: read port 1 is implemented exactly like port 0.
- Not defined: `pr1_s_val` is ignored and `pr1_val` is tied to 0.

## Test plan
- Reset with `hs_angle`=0 and `hs_has_next_angle`=1; host returns val = s*angle+87 with the 5-cycle delay; `pr_next_angle`=1 -> one ack pulse, `pr_angle`=0, and reading s=0..255 returns 87, 87, ... one cycle after each address.
- Host acks angles 20, 40, ... 160 -> `pr_angle` steps through 0, 20, ... 160; at angle 20, s=10 reads 287.
- Hold `pr_next_angle`=0 for 1000 cycles after a fill -> FSM stays FULL, `hs_next_angle`=0, no ack pulse.
- Raise `pr_next_angle` during FILL -> ack is issued exactly 1 cycle after the DRAIN to FULL transition.
- Drop `hs_has_next_angle` while in REQ -> `hs_next_angle` falls and FSM idles; `pr_angle` is unchanged.
- Assert reset mid-fill at s=100 -> all outputs reach reset values asynchronously; the next fill starts at s=0.
